// File: rtl/mem_req_pkg.sv
// Shared types and constants for the delayed main-memory requester.
// The optional WAIT-state timeout is enabled with the MEM_REQ_TIMEOUT_EN macro.
package mem_req_pkg;

    // Default WAIT-state cycle limit used when the timeout feature is built in
    localparam int DEFAULT_TIMEOUT = 255;

    // Requester protocol states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Address width needed to reach every word of a memory LENGTH words deep
    function automatic int addr_width(input int length);
        int width;
        if (length > 1) begin
            width = $clog2(length);
        end else begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/mem_requester.sv
// Single-outstanding initiator for the delayed main memory.
// Accepts one CPU request over valid/ready, drives the memory pins while the
// responder works, and returns read data (old contents on a write) as a
// one-cycle response strobe.
// Optional feature: define MEM_REQ_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles and report an expired wait through rsp_error.
module mem_requester
    import mem_req_pkg::*;
#(
    parameter int  LENGTH      = 1024,
    parameter int  BLOCK_SIZE  = 32,
    parameter int  TIMEOUT     = DEFAULT_TIMEOUT,
    localparam int ADDR_LENGTH = addr_width(LENGTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_LENGTH-1:0] req_addr,
    input  logic [BLOCK_SIZE-1:0]  req_wdata,
    output logic                   rsp_valid,
    output logic [BLOCK_SIZE-1:0]  rsp_rdata,
    output logic                   rsp_error,
    output logic                   mem_enable,
    output logic                   mem_we,
    output logic [ADDR_LENGTH-1:0] mem_addr,
    output logic [BLOCK_SIZE-1:0]  mem_data_in,
    input  logic [BLOCK_SIZE-1:0]  mem_data_out,
    input  logic                   mem_requestComplete
);

    // A zero-cycle wait limit could never be honoured by the WAIT counter
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("mem_requester: TIMEOUT must be at least 1");
    end

    state_t                   state_r;
    state_t                   state_next_s;
    logic                     accept_s;
    logic                     complete_s;
    logic                     timeout_hit_s;

    logic                     req_ready_r;
    logic                     mem_enable_r;
    logic                     rsp_valid_r;
    logic                     mem_we_r;
    logic [ADDR_LENGTH-1:0]   mem_addr_r;
    logic [BLOCK_SIZE-1:0]    mem_data_in_r;
    logic [BLOCK_SIZE-1:0]    rsp_rdata_r;

    // A request is taken only while idle; completion only counts once the
    // responder has had its first enabled cycle to clear the stale flag.
    assign accept_s   = (state_r == ST_IDLE) && req_valid;
    assign complete_s = (state_r == ST_WAIT) && mem_requestComplete;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             rsp_error_r;

    // Count WAIT cycles, restarting from zero each time WAIT is entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= '0;
        end else if (state_r == ST_ISSUE) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != CNT_W'(TIMEOUT))) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The limit fires on the TIMEOUT-th WAIT cycle unless completion arrives with it
    always_comb begin
        timeout_hit_s = 1'b0;
        if ((state_r == ST_WAIT) && !mem_requestComplete &&
            (wait_cnt_r == CNT_W'(TIMEOUT - 1))) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Error flag follows each capture: cleared on completion, set on timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_error_r <= 1'b0;
        end else if (complete_s) begin
            rsp_error_r <= 1'b0;
        end else if (timeout_hit_s) begin
            rsp_error_r <= 1'b1;
        end else begin
            rsp_error_r <= rsp_error_r;
        end
    end

    assign rsp_error = rsp_error_r;
`else
    // Without the timeout the wait is unbounded and errors cannot occur
    always_comb begin
        timeout_hit_s = 1'b0;
    end

    assign rsp_error = 1'b0;
`endif

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (complete_s) begin
                    state_next_s = ST_RESP;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake and enable outputs registered from the next state, so they
    // line up with the state they describe and drop asynchronously on reset.
    // Enable is low in RESP and IDLE, giving the responder a clean rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_r  <= 1'b1;
            mem_enable_r <= 1'b0;
            rsp_valid_r  <= 1'b0;
        end else begin
            req_ready_r  <= (state_next_s == ST_IDLE);
            mem_enable_r <= (state_next_s == ST_ISSUE) || (state_next_s == ST_WAIT);
            rsp_valid_r  <= (state_next_s == ST_RESP);
        end
    end

    // Latch the request into the memory pins; they hold until the next accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_data_in_r <= '0;
        end else if (accept_s) begin
            mem_we_r      <= req_we;
            mem_addr_r    <= req_addr;
            mem_data_in_r <= req_wdata;
        end else begin
            mem_we_r      <= mem_we_r;
            mem_addr_r    <= mem_addr_r;
            mem_data_in_r <= mem_data_in_r;
        end
    end

    // Capture response data on completion (zero on timeout); held otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata_r <= '0;
        end else if (complete_s) begin
            rsp_rdata_r <= mem_data_out;
        end else if (timeout_hit_s) begin
            rsp_rdata_r <= '0;
        end else begin
            rsp_rdata_r <= rsp_rdata_r;
        end
    end

    assign req_ready   = req_ready_r;
    assign mem_enable  = mem_enable_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_data_in = mem_data_in_r;

endmodule
